// File: rtl/dispatch_queue_pkg.sv
// Shared types for the dispatch queue: decoded packet, queue entry and FU class indices.
package dispatch_queue_pkg;

  localparam int DQ_FU_W = 4;

  localparam int FU_ALU = 0;
  localparam int FU_ACU = 1;
  localparam int FU_MEM = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic        illegal;
    logic        valid;
  } ID_EX_PACKET;

  // fu is stored wider than any realistic FU_W and narrowed at the read port
  typedef struct packed {
    ID_EX_PACKET           packet;
    logic [DQ_FU_W-1:0]    fu;
  } DQ_ENTRY;

endpackage

// File: rtl/dispatch_select.sv
// In-order grant chain for dispatch lanes: ROB budget, per-FU RS budget and halt cut-off.
module dispatch_select #(
  parameter int OUT_WIDTH = 2,
  parameter int FU_NUM    = 3,
  parameter int FU_W      = 2,
  parameter int CNT_W     = 2
) (
  input  logic [OUT_WIDTH-1:0]             cand_valid,
  input  logic [OUT_WIDTH-1:0][FU_W-1:0]   cand_fu,
  input  logic [OUT_WIDTH-1:0]             cand_halt,
  input  logic [FU_NUM-1:0][CNT_W-1:0]     rs_free_cnt,
  input  logic [CNT_W-1:0]                 rob_free_cnt,
  input  logic                             block,
  output logic [OUT_WIDTH-1:0]             grant,
  output logic [CNT_W-1:0]                 grant_cnt
);

  logic                         chain_c;
  logic                         fu_ok_c;
  logic [FU_NUM-1:0][CNT_W-1:0] used_c;

  always_comb begin
    chain_c   = !block;
    used_c    = '0;
    grant     = '0;
    grant_cnt = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      fu_ok_c = 1'b0;
      for (int f = 0; f < FU_NUM; f++) begin
        if (cand_fu[k] == FU_W'(f) && used_c[f] < rs_free_cnt[f]) fu_ok_c = 1'b1;
      end
      chain_c  = chain_c && cand_valid[k] && (CNT_W'(k) < rob_free_cnt) && fu_ok_c;
      grant[k] = chain_c;
      if (chain_c) begin
        grant_cnt = grant_cnt + 1'b1;
        for (int f = 0; f < FU_NUM; f++) begin
          if (cand_fu[k] == FU_W'(f)) used_c[f] = used_c[f] + 1'b1;
        end
      end
      // a granted halt is the last lane dispatched this cycle
      chain_c = chain_c && !cand_halt[k];
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// Multi-wide in-order dispatch buffer with flush and halt-drain.
// Optional same-cycle bypass when empty: define DISPATCH_QUEUE_BYPASS_EN.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  parameter int FU_NUM    = 3,
  localparam int FU_W     = (FU_NUM > 1) ? $clog2(FU_NUM) : 1,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int OCW      = $clog2(OUT_WIDTH + 1)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [IN_WIDTH-1:0]                in_valid,
  input  ID_EX_PACKET [IN_WIDTH-1:0]         in_packet,
  input  logic [IN_WIDTH-1:0][FU_W-1:0]      in_fu,
  output logic                               stall_out,
  output logic [CW-1:0]                      free_cnt,
  input  logic [FU_NUM-1:0][OCW-1:0]         rs_free_cnt,
  input  logic [OCW-1:0]                     rob_free_cnt,
  input  logic                               flush,
  output logic [OUT_WIDTH-1:0]               out_valid,
  output ID_EX_PACKET [OUT_WIDTH-1:0]        out_packet,
  output logic [OUT_WIDTH-1:0][FU_W-1:0]     out_fu,
  output logic                               halted
);

  localparam int PW = $clog2(DEPTH);

  DQ_ENTRY          mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             halted_q, halted_d;

  logic             enq_ok;
  logic [CW-1:0]    enq_n;
  logic             bypass;
  logic [CW-1:0]    byp_n;

  DQ_ENTRY [OUT_WIDTH-1:0]           cand_entry;
  logic [OUT_WIDTH-1:0]              cand_valid;
  logic [OUT_WIDTH-1:0][FU_W-1:0]    cand_fu;
  logic [OUT_WIDTH-1:0]              cand_halt;
  logic [OUT_WIDTH-1:0]              grant;
  logic [OCW-1:0]                    grant_cnt;

  assign free_cnt  = CW'(DEPTH) - count_q;
  assign stall_out = free_cnt < CW'(IN_WIDTH);
  assign enq_ok    = !stall_out && !flush;
  assign halted    = halted_q;

  always_comb begin
    enq_n = '0;
    for (int i = 0; i < IN_WIDTH; i++) enq_n = enq_n + CW'(in_valid[i]);
  end

`ifdef DISPATCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && !halted_q && !reset && enq_ok;
`else
  assign bypass = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_cand
      DQ_ENTRY q_entry;
      logic    q_valid;
      assign q_entry = mem_q[head_q + PW'(gi)];
      assign q_valid = CW'(gi) < count_q;
`ifdef DISPATCH_QUEUE_BYPASS_EN
      if (gi < IN_WIDTH) begin : g_byp
        assign cand_entry[gi] = bypass ? DQ_ENTRY'{packet: in_packet[gi], fu: DQ_FU_W'(in_fu[gi])}
                                       : q_entry;
        assign cand_valid[gi] = bypass ? in_valid[gi] : q_valid;
      end else begin : g_nobyp
        assign cand_entry[gi] = q_entry;
        assign cand_valid[gi] = !bypass && q_valid;
      end
`else
      assign cand_entry[gi] = q_entry;
      assign cand_valid[gi] = q_valid;
`endif
      assign cand_fu[gi]    = FU_W'(cand_entry[gi].fu);
      assign cand_halt[gi]  = cand_entry[gi].packet.halt;
      assign out_packet[gi] = cand_entry[gi].packet;
      assign out_fu[gi]     = cand_fu[gi];
    end
  endgenerate

  dispatch_select #(
    .OUT_WIDTH (OUT_WIDTH),
    .FU_NUM    (FU_NUM),
    .FU_W      (FU_W),
    .CNT_W     (OCW)
  ) u_select (
    .cand_valid   (cand_valid),
    .cand_fu      (cand_fu),
    .cand_halt    (cand_halt),
    .rs_free_cnt  (rs_free_cnt),
    .rob_free_cnt (rob_free_cnt),
    .block        (halted_q || flush || reset),
    .grant        (grant),
    .grant_cnt    (grant_cnt)
  );

  assign out_valid = grant;
  assign byp_n     = bypass ? CW'(grant_cnt) : '0;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      // bypassed lanes never occupy storage, so head stays and tail skips them
      head_d   = bypass ? head_q : head_q + PW'(grant_cnt);
      tail_d   = tail_q + PW'(enq_ok ? enq_n : '0) - PW'(byp_n);
      count_d  = count_q + (enq_ok ? enq_n : '0) - CW'(grant_cnt);
      halted_d = halted_q || |(grant & cand_halt);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (enq_ok && in_valid[i] && (CW'(i) >= byp_n))
        mem_q[tail_q + PW'(i) - PW'(byp_n)] <= DQ_ENTRY'{packet: in_packet[i], fu: DQ_FU_W'(in_fu[i])};
    end
  end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised in-order buffer between decode and the reservation stations / ROB. It accepts up to `IN_WIDTH` decoded instructions per cycle and holds them in a circular queue of `DEPTH` entries. It dispatches up to `OUT_WIDTH` per cycle in program order, gated by per-FU RS capacity and ROB capacity. This is the multi-wide, buffered successor to the single-instruction issue path, and adds flush and halt-drain behaviour.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, ≥ max(`IN_WIDTH`, `OUT_WIDTH`).
- `IN_WIDTH`, 2: enqueue lanes per cycle.
- `OUT_WIDTH`, 2: dispatch lanes per cycle.
- `FU_NUM`, 3: RS/FU classes; `FU_W` = $clog2(`FU_NUM`).

Ports (one clock; reset is asynchronous and active-high):
- `clock` in 1: system clock.
- `reset` in 1: async active-high reset.
- `in_valid` in `IN_WIDTH`: lane-valid bits, contiguous from lane 0.
- `in_packet` in `IN_WIDTH`×ID_EX_PACKET: decoded instructions.
- `in_fu` in `IN_WIDTH`×`FU_W`: target RS class per lane.
- `stall_out` out 1: high when free entries < `IN_WIDTH`; no enqueue that cycle.
- `free_cnt` out $clog2(`DEPTH`+1): free entries.
- `rs_free_cnt` in `FU_NUM`×$clog2(`OUT_WIDTH`+1): free RS slots per FU, saturated at `OUT_WIDTH`.
- `rob_free_cnt` in $clog2(`OUT_WIDTH`+1): free ROB slots, saturated at `OUT_WIDTH`.
- `flush` in 1: squash all queued entries.
- `out_valid` out `OUT_WIDTH`: lane k is dispatched (consumed) this cycle.
- `out_packet` out `OUT_WIDTH`×ID_EX_PACKET: packet of lane k (head+k).
- `out_fu` out `OUT_WIDTH`×`FU_W`: RS class for lane k.
- `halted` out 1: a halt has been dispatched and dispatch is frozen.

## Operation
- State: storage array, `head`, `tail` ($clog2(`DEPTH`) bits, wrap mod `DEPTH`), `count` ($clog2(`DEPTH`+1) bits), `halted` flag.
- Enqueue: if `!stall_out && !flush`, each lane i with `in_valid[i]` is written at tail+i. Tail and count advance by popcount(`in_valid`). Enqueue is all-or-nothing. `stall_out` is computed from the current `count` only, not the same-cycle dispatch.
- Dispatch grant for lane k requires all of:
  - lanes 0..k-1 are granted;
  - k < `count`;
  - k < `rob_free_cnt`;
  - earlier granted lanes with the same FU < `rs_free_cnt[fu]`;
  - no earlier granted lane in this cycle is a halt;
  - `!halted`;
  - `!flush`.
- Dispatch is strictly in order. The first blocked lane blocks all later lanes. Head advances and count decreases by the number of granted lanes.
- Halt: a dispatched entry with `halt`=1 sets `halted` at the next edge. After that, `out_valid`=0 until flush or reset. Enqueue continues until the queue is full.
- Flush: at the next edge, head=tail=0, count=0, `halted`=0. During the flush cycle, `out_valid`=0 and enqueue is ignored. Flush overrides every simultaneous event.
- Simultaneous enqueue and dispatch: both apply. count_next = count + enq − deq.
- Empty queue: `out_valid`=0. Full queue: `stall_out`=1 while free < `IN_WIDTH`.
- Invalid or illegal packets are queued and dispatched normally. Squashing them is downstream's job.

## Timing
- Reset values: `out_valid`=0, `stall_out`=0, `free_cnt`=`DEPTH`, `halted`=0, pointers and count 0, `out_packet`/`out_fu` don't-care (array contents not reset).
- Latency: an enqueued entry can dispatch no earlier than the cycle after its write. The exception is under `DISPATCH_QUEUE_BYPASS_EN`.
- `out_*` are combinational from registered state plus the `rs_free_cnt`, `rob_free_cnt` and `flush` inputs. Downstream allocates on `out_valid`; there is no separate ready signal.
- Reset asserted mid-operation clears state immediately (asynchronously). No entry is dispatched while reset is high.

## Configuration
- `DISPATCH_QUEUE_BYPASS_EN` defined:
  - when `count`=0 and the queue is not halted or flushing, input lanes feed dispatch lanes directly in the same cycle, under the same grant rules;
  - bypassed entries are not written;
  - entries that are not granted are written normally.
- Undefined: minimum one-cycle latency through the queue; no input-to-`out_valid` combinational path.

## Structure
- Add to `sys_defs.svh`:
  - `FU_ALU`/`FU_ACU` indices (existing);
  - typedef `DQ_ENTRY` {ID_EX_PACKET packet; logic [FU_W-1:0] fu;}.
- Sub-module `dispatch_select`: combinational per-lane grant chain (ROB budget, per-FU running counts, halt cut-off), instantiated once.

## Test plan
- Reset, then enqueue 2 ALU ops with `rs_free_cnt[ALU]`=2 and `rob_free_cnt`=2 -> next cycle `out_valid`=2'b11, then `count`=0.
- Fill 8 entries with dispatch blocked (`rob_free_cnt`=0) -> `stall_out`=1 and `free_cnt`=0; a further `in_valid`=2'b11 is dropped. Release ROB -> head wraps and order is preserved.
- Head pair both ACU with `rs_free_cnt[ACU]`=1 -> only lane 0 dispatches; lane 1 dispatches the following cycle.
- Halt at head+0 with a valid op behind it -> `out_valid`=2'b01, then `halted`=1 and `out_valid`=0 until `flush`.
- `flush` with 5 entries and a simultaneous enqueue -> next cycle `count`=0, `free_cnt`=8, `out_valid`=0, `halted`=0.
- With `DISPATCH_QUEUE_BYPASS_EN` and the queue empty, enqueue 1 op -> `out_valid[0]`=1 in the same cycle and `count` stays 0.
